// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator: sequential/branch/JAL/JALR/trap next-PC with a one-entry redirect buffer.
// Optional misaligned-target check enabled by defining PC_MISALIGN_CHK_EN (adds misalign_o).
module pc_gen_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              IMM_SHIFT   = 1,
  parameter int              INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            op_valid_i,
  input  logic [6:0]      op_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            if_ready_i,
  output logic            if_req_o,
  output logic [XLEN-1:0] pc_o,
  output logic            ce_o,
  output logic            redirect_o,
  output logic            illegal_o
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic            misalign_o
`endif
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [XLEN-1:0] INC = XLEN'(INSTR_BYTES);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state, state_nxt;
  logic            adv, trap_take;
  logic            live_jump, unknown;
  logic [XLEN-1:0] seq_tgt, live_tgt;
  logic            pend_vld, pend_vld_nxt;
  logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            redirect_nxt, illegal_nxt;
`ifdef PC_MISALIGN_CHK_EN
  logic            misalign_nxt;
`endif

  // JALR targets always drop bit 0 regardless of alignment checking.
  function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] base,
                                                  input logic [XLEN-1:0] ofs);
    logic [XLEN-1:0] sum;
    sum = base + ofs;
    return {sum[XLEN-1:1], 1'b0};
  endfunction

  assign if_req_o  = (state == RUN);
  assign adv       = if_req_o & if_ready_i & ~stall_i;
  assign trap_take = trap_i & ce_o;

  always_comb begin
    seq_tgt   = pc_o + INC;
    live_tgt  = seq_tgt;
    live_jump = 1'b0;
    unknown   = 1'b0;
    case (op_i)
      OP_BRANCH: begin
        if (br_taken_i) begin
          live_jump = 1'b1;
          live_tgt  = pc_o + (imm_i << IMM_SHIFT);
        end
      end
      OP_JAL: begin
        live_jump = 1'b1;
        live_tgt  = pc_o + (imm_i << IMM_SHIFT);
      end
      OP_JALR: begin
        live_jump = 1'b1;
        live_tgt  = jalr_target(rs1_i, imm_i);
      end
      OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_SYSTEM: ;
      default: unknown = 1'b1;
    endcase
    if (!op_valid_i) begin
      live_jump = 1'b0;
      live_tgt  = seq_tgt;
      unknown   = 1'b0;
    end
  end

  // Priority: trap, then a buffered redirect, then the live op, then sequential.
  always_comb begin
    pc_nxt       = pc_o;
    pend_vld_nxt = pend_vld;
    pend_tgt_nxt = pend_tgt;
    redirect_nxt = 1'b0;
    illegal_nxt  = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
    misalign_nxt = 1'b0;
`endif
    if (trap_take) begin
      pc_nxt       = trap_vec_i;
      pend_vld_nxt = 1'b0;
      redirect_nxt = 1'b1;
    end else if (adv && pend_vld) begin
      pc_nxt       = pend_tgt;
      pend_vld_nxt = 1'b0;
      redirect_nxt = 1'b1;
    end else if (ce_o) begin
      illegal_nxt = unknown;
`ifdef PC_MISALIGN_CHK_EN
      if (live_jump && (live_tgt[1:0] != 2'b00)) begin
        misalign_nxt = 1'b1;
        pend_vld_nxt = 1'b0;
      end else
`endif
      if (adv) begin
        pc_nxt       = live_tgt;
        redirect_nxt = live_jump;
      end else if (live_jump) begin
        pend_vld_nxt = 1'b1;
        pend_tgt_nxt = live_tgt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (stall_i) state_nxt = HOLD;
      HOLD:    if (!stall_i) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
    if (trap_take) state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      ce_o       <= 1'b0;
      pc_o       <= RESET_VEC;
      pend_vld   <= 1'b0;
      pend_tgt   <= '0;
      redirect_o <= 1'b0;
      illegal_o  <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      ce_o       <= 1'b1;
      pc_o       <= pc_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_tgt   <= pend_tgt_nxt;
      redirect_o <= redirect_nxt;
      illegal_o  <= illegal_nxt;
`ifdef PC_MISALIGN_CHK_EN
      misalign_o <= misalign_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit; misalign checks run only when PC_MISALIGN_CHK_EN is defined.
module tb_pc_gen_unit;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, op_valid_i, br_taken_i, trap_i, if_ready_i;
  logic [6:0]  op_i;
  logic [31:0] imm_i, rs1_i, trap_vec_i;
  logic        if_req_o, ce_o, redirect_o, illegal_o;
  logic [31:0] pc_o;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h0), .IMM_SHIFT(1), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .op_valid_i(op_valid_i), .op_i(op_i),
    .br_taken_i(br_taken_i), .imm_i(imm_i), .rs1_i(rs1_i), .trap_i(trap_i),
    .trap_vec_i(trap_vec_i), .if_ready_i(if_ready_i), .if_req_o(if_req_o), .pc_o(pc_o),
    .ce_o(ce_o), .redirect_o(redirect_o), .illegal_o(illegal_o)
`ifdef PC_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [6:0] code, input logic [31:0] imm, input logic [31:0] rs1,
                    input logic taken);
    op_valid_i = 1'b1;
    op_i       = code;
    imm_i      = imm;
    rs1_i      = rs1;
    br_taken_i = taken;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; op_valid_i = 1'b0; op_i = 7'h0; br_taken_i = 1'b0;
    imm_i = '0; rs1_i = '0; trap_i = 1'b0; trap_vec_i = '0; if_ready_i = 1'b1;
    step(); step();
    check("rst_pc", pc_o, 32'h0);
    check("rst_ce", {31'b0, ce_o}, 32'h0);
    check("rst_req", {31'b0, if_req_o}, 32'h0);
    check("rst_redir", {31'b0, redirect_o}, 32'h0);
    check("rst_ill", {31'b0, illegal_o}, 32'h0);

    rst_n = 1'b1;
    step();
    check("boot_ce", {31'b0, ce_o}, 32'h1);
    check("boot_req", {31'b0, if_req_o}, 32'h1);
    check("boot_pc", pc_o, 32'h0);
    step(); check("seq_4", pc_o, 32'h4);
    step(); check("seq_8", pc_o, 32'h8);
    step(); check("seq_c", pc_o, 32'hC);
    for (int i = 0; i < 5; i++) step();
    check("seq_20", pc_o, 32'h20);

    op(OP_BRANCH, 32'h8, 32'h0, 1'b1);
    step();
    check("br_taken_pc", pc_o, 32'h30);
    check("br_taken_redir", {31'b0, redirect_o}, 32'h1);
    op_valid_i = 1'b0;
    step();
    check("after_br_pc", pc_o, 32'h34);
    check("after_br_redir", {31'b0, redirect_o}, 32'h0);

    trap_i = 1'b1; trap_vec_i = 32'h20;
    step();
    check("trap20_pc", pc_o, 32'h20);
    check("trap20_redir", {31'b0, redirect_o}, 32'h1);
    trap_i = 1'b0;
    op(OP_BRANCH, 32'h8, 32'h0, 1'b0);
    step();
    check("br_nt_pc", pc_o, 32'h24);
    check("br_nt_redir", {31'b0, redirect_o}, 32'h0);
    op_valid_i = 1'b0;

    trap_i = 1'b1; trap_vec_i = 32'h40;
    step();
    trap_i = 1'b0;
    check("trap40_pc", pc_o, 32'h40);
    stall_i = 1'b1;
    op(OP_JAL, 32'hFFFF_FFF0, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0;
    check("stall1_pc", pc_o, 32'h40);
    check("stall1_req", {31'b0, if_req_o}, 32'h0);
    step(); step();
    check("stall3_pc", pc_o, 32'h40);
    stall_i = 1'b0;
    step();
    check("unstall_pc", pc_o, 32'h40);
    check("unstall_req", {31'b0, if_req_o}, 32'h1);
    step();
    check("pend_jal_pc", pc_o, 32'h20);
    check("pend_jal_redir", {31'b0, redirect_o}, 32'h1);
    step();
    check("post_pend_pc", pc_o, 32'h24);
    check("post_pend_redir", {31'b0, redirect_o}, 32'h0);

    stall_i = 1'b1;
    op(OP_JAL, 32'h10, 32'h0, 1'b0);
    step();
    op(OP_JAL, 32'h20, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0; stall_i = 1'b0;
    step();
    step();
    check("youngest_pc", pc_o, 32'h64);
    check("youngest_redir", {31'b0, redirect_o}, 32'h1);

    stall_i = 1'b1;
    op(OP_JAL, 32'h8, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0; stall_i = 1'b0;
    step();
    op(OP_JAL, 32'h100, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0;
    check("pend_over_live_pc", pc_o, 32'h74);

    if_ready_i = 1'b0;
    op(OP_JALR, 32'h4, 32'h1001, 1'b0);
    step();
    op_valid_i = 1'b0;
    check("notready_hold_pc", pc_o, 32'h74);
    if_ready_i = 1'b1;
    step();
    check("jalr_pend_pc", pc_o, 32'h1004);
    check("jalr_pend_redir", {31'b0, redirect_o}, 32'h1);

    op(OP_JALR, 32'h4, 32'h1001, 1'b0);
    trap_i = 1'b1; trap_vec_i = 32'h100;
    step();
    trap_i = 1'b0;
    check("trap_wins_pc", pc_o, 32'h100);
    op(OP_JALR, 32'h3, 32'h2001, 1'b0);
    step();
    op_valid_i = 1'b0;
    check("jalr_live_pc", pc_o, 32'h2004);
    check("jalr_live_redir", {31'b0, redirect_o}, 32'h1);

    stall_i = 1'b1;
    op(OP_JAL, 32'h40, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0;
    trap_i = 1'b1; trap_vec_i = 32'h300;
    step();
    trap_i = 1'b0;
    check("trap_stall_pc", pc_o, 32'h300);
    check("trap_stall_req", {31'b0, if_req_o}, 32'h1);
    check("trap_stall_redir", {31'b0, redirect_o}, 32'h1);
    step();
    check("trap_rehold_req", {31'b0, if_req_o}, 32'h0);
    stall_i = 1'b0;
    step();
    step();
    check("trap_clr_pend_pc", pc_o, 32'h304);
    check("trap_clr_pend_redir", {31'b0, redirect_o}, 32'h0);

    trap_i = 1'b1; trap_vec_i = 32'hFFFF_FFFC;
    step();
    trap_i = 1'b0;
    step();
    check("wrap_pc", pc_o, 32'h0);
    op(7'h7F, 32'h0, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0;
    check("illegal_pc", pc_o, 32'h4);
    check("illegal_pulse", {31'b0, illegal_o}, 32'h1);
    step();
    check("illegal_clear", {31'b0, illegal_o}, 32'h0);
    check("illegal_next_pc", pc_o, 32'h8);

`ifdef PC_MISALIGN_CHK_EN
    op(OP_JAL, 32'h1, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0;
    check("misalign_hold_pc", pc_o, 32'h8);
    check("misalign_pulse", {31'b0, misalign_o}, 32'h1);
    check("misalign_no_redir", {31'b0, redirect_o}, 32'h0);
    step();
    check("misalign_clear", {31'b0, misalign_o}, 32'h0);
    check("misalign_next_pc", pc_o, 32'hC);
`endif

    stall_i = 1'b1;
    op(OP_JAL, 32'h10, 32'h0, 1'b0);
    step();
    op_valid_i = 1'b0; stall_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc_o, 32'h0);
    check("async_rst_ce", {31'b0, ce_o}, 32'h0);
    check("async_rst_req", {31'b0, if_req_o}, 32'h0);
    trap_i = 1'b1; trap_vec_i = 32'h500;
    step();
    rst_n = 1'b1;
    step();
    check("boot_trap_pc", pc_o, 32'h0);
    check("boot_trap_redir", {31'b0, redirect_o}, 32'h0);
    check("boot_trap_ce", {31'b0, ce_o}, 32'h1);
    trap_i = 1'b0;
    step();
    check("rst_clr_pend_pc", pc_o, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
